lcd_clock_gen: RTL and testbench
================================

// Module: lcd_clock_gen
// PURPOSE
//  Parametrised clock generator for the LCD serial interface. It produces a
//  complementary pair scl_lcd/scl_func with a runtime-programmable half-period.
//  Adds a glitch-free start/stop, a divisor-update handshake, edge strobes and
//  optional clock stretching. Sits between the system clock and the LCD
//  driver/command FSM.
// PARAMETERS
//  WIDTH        4  width of the divisor and the phase counter
//  DEFAULT_DIV  7  half-period divisor after reset; must be < 2**WIDTH
// PORTS
//  clock     in   1      system clock; all logic on posedge
//  reset     in   1      synchronous, active-high
//  enable    in   1      run request (level)
//  div_in    in   WIDTH  new divisor; half-period = div+1 clock cycles
//  div_load  in   1      1-cycle request to adopt div_in
//  div_ack   out  1      1-cycle pulse in the cycle the new divisor becomes active
//  scl_lcd   out  1      generated clock; low when idle
//  scl_func  out  1      always ~scl_lcd
//  rise_stb  out  1      1-cycle pulse, registered with scl_lcd 0->1
//  fall_stb  out  1      1-cycle pulse, registered with scl_lcd 1->0
//  running   out  1      high in LOW/HIGH states
//  hold      in   1      only with LCD_CLKGEN_STRETCH_EN; extends the high phase
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, cnt=0, div_act=DEFAULT_DIV, pending cleared.
//   - scl_lcd=0, scl_func=1; div_ack, rise_stb, fall_stb, running all 0.
//   - Reset asserted mid-operation wins over everything, effective next edge.
//  All outputs are registered.
//  FSM:
//   - IDLE: scl=0, cnt=0. enable=1 -> LOW, cnt=0.
//   - LOW: cnt++. At cnt==div_act, cnt<=0:
//       enable=1 -> HIGH, scl<=1, rise_stb;
//       enable=0 -> IDLE.
//     enable=0 before terminal -> IDLE next edge (scl already 0, glitch-free).
//   - HIGH: cnt++. Always completes the full high phase; enable is ignored
//     until terminal. At cnt==div_act: scl<=0, fall_stb, cnt<=0;
//     next state is LOW if enable=1, else IDLE.
//  Timing: LOW and HIGH each last div_act+1 cycles; period = 2*(div_act+1).
//   - div=0 gives clock/2.
//   - DEFAULT_DIV=7 gives clock/16; first rise 8 cycles after entering LOW.
//  Divisor handshake:
//   - div_load latches div_in into pending.
//   - A later load before apply overwrites pending; only one ack results.
//   - Apply: in IDLE, the cycle after the load; else at the HIGH terminal
//     (same edge as fall_stb). div_ack pulses on that edge.
//   - div_act never changes mid-phase.
//   - div_load on the apply edge: current pending applies, the new value stays
//     pending for the next boundary.
//  Counter: WIDTH bits, never exceeds div_act, so it never wraps.
// CONFIGURATION
//  LCD_CLKGEN_STRETCH_EN defined:
//   - hold port exists.
//   - In HIGH at cnt==div_act with hold=1: stay HIGH, cnt held, no fall_stb.
//   - On the first cycle with hold=0, the terminal action executes.
//   - hold has no effect in IDLE or LOW.
//  Undefined: no hold port; HIGH always ends after div_act+1 cycles.
// TESTING
//  1. Reset mid-HIGH, div_act=3 -> next cycle scl_lcd=0, scl_func=1,
//     running=0, div_act=7.
//  2. enable=1 from reset, DEFAULT_DIV=7 -> rise_stb 8 cycles after LOW entry;
//     fall 8 later; period 16; rise_stb/fall_stb one cycle each.
//  3. div_load div_in=3 mid-HIGH -> div_ack coincides with fall_stb;
//     following period = 8 cycles.
//  4. div_in=0 loaded in IDLE -> div_ack next cycle; after enable, scl toggles
//     every cycle (period 2).
//  5. enable=0 at cnt=2 of HIGH -> high lasts the full 8 cycles, then IDLE,
//     scl=0; enable=0 in LOW -> IDLE next edge, no rise.
//  6. STRETCH_EN, hold=1 for 5 cycles at HIGH terminal -> high lasts 13 cycles,
//     fall_stb in the first cycle with hold=0.

Source files
------------

// File: rtl/lcd_clock_gen.sv
// Clock generator for the LCD serial interface: complementary scl pair with a
// programmable half-period, divisor handshake and edge strobes.
// Optional high-phase stretching via the hold input when LCD_CLKGEN_STRETCH_EN is defined.
module lcd_clock_gen #(
    parameter int WIDTH       = 4,
    parameter int DEFAULT_DIV = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
`ifdef LCD_CLKGEN_STRETCH_EN
    input  logic             hold,
`endif
    output logic             div_ack,
    output logic             scl_lcd,
    output logic             scl_func,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic             running
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] pending;
    logic             pend_vld;
    logic             hold_eff;
    logic             at_term;
    logic             high_term;
    logic             apply;

`ifdef LCD_CLKGEN_STRETCH_EN
    assign hold_eff = hold;
`else
    assign hold_eff = 1'b0;
`endif

    assign at_term   = (cnt == div_act);
    assign high_term = (state == HIGH) && at_term && !hold_eff;
    // A new divisor only takes effect at a phase boundary, so cnt never passes div_act.
    assign apply     = pend_vld && ((state == IDLE) || high_term);

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            div_act  <= WIDTH'(DEFAULT_DIV);
            pending  <= '0;
            pend_vld <= 1'b0;
            scl_lcd  <= 1'b0;
            scl_func <= 1'b1;
            div_ack  <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
            running  <= 1'b0;
        end else begin
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
            div_ack  <= 1'b0;

            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (enable) begin
                        state   <= LOW;
                        running <= 1'b1;
                    end
                end
                LOW: begin
                    if (!enable) begin
                        // scl is already low here, so dropping out is glitch-free
                        state   <= IDLE;
                        running <= 1'b0;
                        cnt     <= '0;
                    end else if (at_term) begin
                        state    <= HIGH;
                        cnt      <= '0;
                        scl_lcd  <= 1'b1;
                        scl_func <= 1'b0;
                        rise_stb <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (high_term) begin
                        state    <= enable ? LOW : IDLE;
                        running  <= enable;
                        cnt      <= '0;
                        scl_lcd  <= 1'b0;
                        scl_func <= 1'b1;
                        fall_stb <= 1'b1;
                    end else if (!at_term) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    cnt     <= '0;
                end
            endcase

            if (apply) begin
                div_act  <= pending;
                div_ack  <= 1'b1;
                pend_vld <= 1'b0;
            end
            // A load on the apply edge stays pending for the next boundary.
            if (div_load) begin
                pending  <= div_in;
                pend_vld <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_lcd_clock_gen.sv
// Scoreboard bench for lcd_clock_gen: expected strobe events (kind, cycle) are
// queued as stimulus is driven and matched against DUT strobes as they appear.
module tb_lcd_clock_gen;
    localparam int WIDTH = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             hold;
    logic             div_ack, scl_lcd, scl_func, rise_stb, fall_stb, running;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    localparam int EV_ACK  = 1;
    localparam int EV_RISE = 2;
    localparam int EV_FALL = 3;

    ev_t exp_q[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;

    lcd_clock_gen #(.WIDTH(WIDTH), .DEFAULT_DIV(7)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .div_in   (div_in),
        .div_load (div_load),
`ifdef LCD_CLKGEN_STRETCH_EN
        .hold     (hold),
`endif
        .div_ack  (div_ack),
        .scl_lcd  (scl_lcd),
        .scl_func (scl_func),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb),
        .running  (running)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic obs(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_ev", kind, 0);
        end else begin
            e = exp_q.pop_front();
            chk("ev_kind", kind, e.kind);
            chk("ev_cycle", cyc, e.at);
        end
    endtask

    // Same-cycle events are popped in the order ack, rise, fall.
    always @(negedge clock) begin
        if (div_ack)  obs(EV_ACK);
        if (rise_stb) obs(EV_RISE);
        if (fall_stb) obs(EV_FALL);
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle %0d exp finish", cyc);
        $fatal(1);
    end

    initial begin
        int b;
        reset    = 1'b1;
        enable   = 1'b0;
        div_in   = '0;
        div_load = 1'b0;
        hold     = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_scl_lcd",  scl_lcd,  0);
        chk("rst_scl_func", scl_func, 1);
        chk("rst_running",  running,  0);
        chk("rst_rise",     rise_stb, 0);
        chk("rst_fall",     fall_stb, 0);
        chk("rst_ack",      div_ack,  0);

        // Default divisor 7: rise 8 cycles after LOW entry, period 16; then
        // drop enable at cnt=2 of the second HIGH -> full high phase, then IDLE.
        b = cyc;
        reset  = 1'b0;
        enable = 1'b1;
        push(EV_RISE, b + 9);
        push(EV_FALL, b + 17);
        push(EV_RISE, b + 25);
        push(EV_FALL, b + 33);
        wait_until(b + 1);
        chk("low_running", running, 1);
        chk("low_scl", scl_lcd, 0);
        wait_until(b + 9);
        chk("hi_scl_lcd", scl_lcd, 1);
        chk("hi_scl_func", scl_func, 0);
        wait_until(b + 27);
        enable = 1'b0;
        wait_until(b + 32);
        chk("hi_full_phase", scl_lcd, 1);
        wait_until(b + 33);
        chk("stop_scl", scl_lcd, 0);
        chk("stop_running", running, 0);

        // enable dropped during LOW: back to IDLE next edge, no rise
        wait_until(b + 35);
        b = cyc;
        enable = 1'b1;
        wait_until(b + 3);
        enable = 1'b0;
        wait_until(b + 4);
        chk("low_abort_running", running, 0);
        wait_until(b + 16);
        chk("low_abort_scl", scl_lcd, 0);

        // Load div 3 mid-HIGH: ack with the fall, then period 8
        b = cyc;
        enable = 1'b1;
        push(EV_RISE, b + 9);
        push(EV_ACK,  b + 17);
        push(EV_FALL, b + 17);
        push(EV_RISE, b + 21);
        push(EV_FALL, b + 25);
        push(EV_RISE, b + 29);
        push(EV_FALL, b + 33);
        wait_until(b + 11);
        div_in   = 4'd3;
        div_load = 1'b1;
        wait_until(b + 12);
        div_load = 1'b0;
        wait_until(b + 30);
        enable = 1'b0;
        wait_until(b + 35);
        chk("div3_idle_running", running, 0);

        // Load div 0 in IDLE: ack next cycle, then scl toggles every cycle
        b = cyc;
        div_in   = 4'd0;
        div_load = 1'b1;
        push(EV_ACK, b + 2);
        wait_until(b + 1);
        div_load = 1'b0;
        wait_until(b + 3);
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            push(EV_RISE, b + 5 + 2 * k);
            push(EV_FALL, b + 6 + 2 * k);
        end
        for (int c = 5; c <= 10; c++) begin
            wait_until(b + c);
            chk("div0_scl", scl_lcd, (c % 2 == 1) ? 1 : 0);
        end
        enable = 1'b0;
        wait_until(b + 13);
        chk("div0_stop_running", running, 0);

        // Reset mid-HIGH with div 3: outputs clear and divisor returns to 7
        b = cyc;
        div_in   = 4'd3;
        div_load = 1'b1;
        push(EV_ACK, b + 2);
        wait_until(b + 1);
        div_load = 1'b0;
        wait_until(b + 2);
        enable = 1'b1;
        push(EV_RISE, b + 7);
        wait_until(b + 8);
        chk("pre_rst_scl", scl_lcd, 1);
        reset = 1'b1;
        wait_until(b + 9);
        chk("mid_rst_scl_lcd",  scl_lcd,  0);
        chk("mid_rst_scl_func", scl_func, 1);
        chk("mid_rst_running",  running,  0);
        reset = 1'b0;
        push(EV_RISE, b + 18);
        push(EV_FALL, b + 26);
        wait_until(b + 19);
        enable = 1'b0;
        wait_until(b + 28);
        chk("post_rst_running", running, 0);

`ifdef LCD_CLKGEN_STRETCH_EN
        // hold for 5 cycles at the HIGH terminal -> high lasts 13 cycles
        b = cyc;
        enable = 1'b1;
        push(EV_RISE, b + 9);
        push(EV_FALL, b + 22);
        wait_until(b + 10);
        enable = 1'b0;
        wait_until(b + 16);
        hold = 1'b1;
        wait_until(b + 21);
        hold = 1'b0;
        chk("stretch_scl", scl_lcd, 1);
        wait_until(b + 22);
        chk("stretch_fall_scl", scl_lcd, 0);
        wait_until(b + 24);
`endif

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
